// File: rtl/load_use_stall_ctrl_pkg.sv
// Shared decode-stage definitions for the load-use stall controller:
// load opcode, NOP encoding and the stall FSM state type.
package proc_pkg;

  localparam logic [3:0]  OP_LOAD   = 4'b1110;
  localparam logic [15:0] NOP_INSTR = '0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/load_use_stall_ctrl.sv
// Load-use stall controller and IF/ID pipeline register.
// Optional feature: define STALL_STATS_EN to add the stall_total bubble counter.
module load_use_stall_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] fetch_instr,
  input  logic               fetch_valid,
  input  logic               hz_a,
  input  logic               hz_b,
  input  logic               ex_ready,
  input  logic               flush,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               ifid_valid,
  output logic               stall_pc,
  output logic               bubble_ex,
  output logic [CNT_W-1:0]   stall_cnt
`ifdef STALL_STATS_EN
  ,
  output logic [15:0]        stall_total
`endif
);

  localparam logic [CNT_W-1:0]   LAT_M1 = CNT_W'(LOAD_LAT - 1);
  localparam logic [INSTR_W-1:0] NOP    = INSTR_W'(NOP_INSTR);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [INSTR_W-1:0]   r_instr;
  logic                 r_valid;
  logic                 w_hazard;

  // Flush outranks freeze, freeze outranks any hazard or pending stall.
  always_comb begin
    w_hazard  = r_valid & (hz_a | hz_b);
    stall_pc  = 1'b0;
    bubble_ex = 1'b0;
    if (flush) begin
      bubble_ex = 1'b1;
    end else if (!ex_ready) begin
      stall_pc = 1'b1;
    end else if ((r_state == STALL) || w_hazard) begin
      stall_pc  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_instr <= NOP;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_instr <= NOP;
      r_valid <= 1'b0;
    end else if (ex_ready) begin
      unique case (r_state)
        STALL: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          if (w_hazard) begin
            // The hazard cycle itself is the first stall cycle.
            if (LOAD_LAT > 1) begin
              r_state <= STALL;
              r_cnt   <= LAT_M1;
            end
          end else begin
            r_instr <= fetch_valid ? fetch_instr : NOP;
            r_valid <= fetch_valid;
          end
        end
      endcase
    end
  end

  assign ifid_instr = r_instr;
  assign ifid_valid = r_valid;
  assign stall_cnt  = r_cnt;

`ifdef STALL_STATS_EN
  logic [15:0] r_total;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_total <= '0;
    end else if (bubble_ex && !flush && (r_total != '1)) begin
      r_total <= r_total + 16'd1;
    end
  end

  assign stall_total = r_total;
`endif

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Bench for load_use_stall_ctrl: three instances (LOAD_LAT 1, 3, 2) on shared stimulus.
// Stats checks are compiled in when STALL_STATS_EN is defined.
`timescale 1ns/1ps
module tb_load_use_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] fetch_instr;
  logic        fetch_valid;
  logic        hz_a, hz_b, ex_ready, flush;

  logic [15:0] d_instr [3];
  logic        d_valid [3];
  logic        d_spc   [3];
  logic        d_bub   [3];
  logic [3:0]  d_cnt   [3];
`ifdef STALL_STATS_EN
  logic [15:0] d_total [3];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_use_stall_ctrl #(.INSTR_W(16), .LOAD_LAT(1), .CNT_W(4)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .fetch_instr(fetch_instr), .fetch_valid(fetch_valid),
    .hz_a(hz_a), .hz_b(hz_b), .ex_ready(ex_ready), .flush(flush),
    .ifid_instr(d_instr[0]), .ifid_valid(d_valid[0]), .stall_pc(d_spc[0]),
    .bubble_ex(d_bub[0]), .stall_cnt(d_cnt[0])
`ifdef STALL_STATS_EN
    , .stall_total(d_total[0])
`endif
  );

  load_use_stall_ctrl #(.INSTR_W(16), .LOAD_LAT(3), .CNT_W(4)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .fetch_instr(fetch_instr), .fetch_valid(fetch_valid),
    .hz_a(hz_a), .hz_b(hz_b), .ex_ready(ex_ready), .flush(flush),
    .ifid_instr(d_instr[1]), .ifid_valid(d_valid[1]), .stall_pc(d_spc[1]),
    .bubble_ex(d_bub[1]), .stall_cnt(d_cnt[1])
`ifdef STALL_STATS_EN
    , .stall_total(d_total[1])
`endif
  );

  load_use_stall_ctrl #(.INSTR_W(16), .LOAD_LAT(2), .CNT_W(4)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .fetch_instr(fetch_instr), .fetch_valid(fetch_valid),
    .hz_a(hz_a), .hz_b(hz_b), .ex_ready(ex_ready), .flush(flush),
    .ifid_instr(d_instr[2]), .ifid_valid(d_valid[2]), .stall_pc(d_spc[2]),
    .bubble_ex(d_bub[2]), .stall_cnt(d_cnt[2])
`ifdef STALL_STATS_EN
    , .stall_total(d_total[2])
`endif
  );

  // Reference model: stall budget in cycles still owed after the current one.
  logic [15:0] m_instr [3];
  bit          m_valid [3];
  int          m_left  [3];
  int          m_total [3];

  function automatic int lat(int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 2;
  endfunction

  function automatic bit m_stalling(int i);
    return (m_left[i] > 0) || (m_valid[i] && (hz_a || hz_b));
  endfunction

  // {stall_pc, bubble_ex} required this cycle
  function automatic logic [1:0] exp_ctl(int i);
    if (flush)     return 2'b01;
    if (!ex_ready) return 2'b10;
    if (m_stalling(i)) return 2'b11;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_instr[i] = '0; m_valid[i] = 0; m_left[i] = 0; m_total[i] = 0;
      end else if (flush) begin
        m_instr[i] = '0; m_valid[i] = 0; m_left[i] = 0;
      end else if (ex_ready) begin
        if (m_stalling(i) && m_total[i] < 65535) m_total[i]++;
        if (m_left[i] > 0)                     m_left[i]--;
        else if (m_valid[i] && (hz_a || hz_b)) m_left[i] = lat(i) - 1;
        else begin
          m_instr[i] = fetch_valid ? fetch_instr : 16'h0000;
          m_valid[i] = fetch_valid;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    hz_a = 1'b0; hz_b = 1'b0; fetch_valid = 1'b0; fetch_instr = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load_instr(input logic [15:0] v);
    fetch_instr = v; fetch_valid = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks += 4;
      if (d_valid[i] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", i, d_valid[i]); end
      if (d_instr[i] !== 16'h0000) begin n_fail++; $display("FAIL reset_instr[%0d]: got %h want 0000", i, d_instr[i]); end
      if (d_spc[i] !== 1'b0) begin n_fail++; $display("FAIL reset_stall_pc[%0d]: got %b want 0", i, d_spc[i]); end
      if (d_cnt[i] !== 4'd0) begin n_fail++; $display("FAIL reset_cnt[%0d]: got %0d want 0", i, d_cnt[i]); end
    end
  endtask

  task automatic test_lat1();
    do_reset();
    load_instr(16'hABCD);
    hz_a = 1'b1; fetch_instr = 16'h1234; #1;
    n_checks += 2;
    if (d_spc[0] !== 1'b1) begin n_fail++; $display("FAIL lat1_stall_pc: got %b want 1", d_spc[0]); end
    if (d_bub[0] !== 1'b1) begin n_fail++; $display("FAIL lat1_bubble: got %b want 1", d_bub[0]); end
    tick(); hz_a = 1'b0; #1;
    n_checks += 3;
    if (d_instr[0] !== 16'hABCD) begin n_fail++; $display("FAIL lat1_hold: got %h want abcd", d_instr[0]); end
    if (d_spc[0] !== 1'b0) begin n_fail++; $display("FAIL lat1_release_pc: got %b want 0", d_spc[0]); end
    if (d_bub[0] !== 1'b0) begin n_fail++; $display("FAIL lat1_release_bub: got %b want 0", d_bub[0]); end
    tick(); #1;
    n_checks += 2;
    if (d_instr[0] !== 16'h1234) begin n_fail++; $display("FAIL lat1_next_instr: got %h want 1234", d_instr[0]); end
    if (d_valid[0] !== 1'b1) begin n_fail++; $display("FAIL lat1_next_valid: got %b want 1", d_valid[0]); end
  endtask

  task automatic test_lat3();
    do_reset();
    load_instr(16'h5555);
    hz_b = 1'b1; fetch_instr = 16'h6666; #1;
    n_checks += 2;
    if (d_bub[1] !== 1'b1) begin n_fail++; $display("FAIL lat3_hz_bubble: got %b want 1", d_bub[1]); end
    if (d_cnt[1] !== 4'd0) begin n_fail++; $display("FAIL lat3_hz_cnt: got %0d want 0", d_cnt[1]); end
    for (int k = 0; k < 2; k++) begin
      tick(); #1;
      n_checks += 3;
      if (d_cnt[1] !== 4'(2 - k)) begin n_fail++; $display("FAIL lat3_cnt%0d: got %0d want %0d", k, d_cnt[1], 2 - k); end
      if ({d_spc[1], d_bub[1]} !== 2'b11) begin n_fail++; $display("FAIL lat3_stall%0d: got %b want 11", k, {d_spc[1], d_bub[1]}); end
      if (d_instr[1] !== 16'h5555) begin n_fail++; $display("FAIL lat3_hold%0d: got %h want 5555", k, d_instr[1]); end
    end
    hz_b = 1'b0;
    tick(); #1;
    n_checks += 3;
    if (d_cnt[1] !== 4'd0) begin n_fail++; $display("FAIL lat3_end_cnt: got %0d want 0", d_cnt[1]); end
    if ({d_spc[1], d_bub[1]} !== 2'b00) begin n_fail++; $display("FAIL lat3_end_run: got %b want 00", {d_spc[1], d_bub[1]}); end
    if (d_instr[1] !== 16'h5555) begin n_fail++; $display("FAIL lat3_end_hold: got %h want 5555", d_instr[1]); end
    tick(); #1;
    n_checks++;
    if (d_instr[1] !== 16'h6666) begin n_fail++; $display("FAIL lat3_reload: got %h want 6666", d_instr[1]); end
  endtask

  task automatic test_flush_in_stall();
    do_reset();
    load_instr(16'h4242);
    hz_b = 1'b1;
    tick();
    flush = 1'b1; #1;
    n_checks += 2;
    if (d_cnt[1] !== 4'd2) begin n_fail++; $display("FAIL flush_pre_cnt: got %0d want 2", d_cnt[1]); end
    if ({d_spc[1], d_bub[1]} !== 2'b01) begin n_fail++; $display("FAIL flush_ctl: got %b want 01", {d_spc[1], d_bub[1]}); end
    tick(); flush = 1'b0; #1;
    n_checks += 4;
    if (d_valid[1] !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", d_valid[1]); end
    if (d_instr[1] !== 16'h0000) begin n_fail++; $display("FAIL flush_instr: got %h want 0000", d_instr[1]); end
    if (d_cnt[1] !== 4'd0) begin n_fail++; $display("FAIL flush_cnt: got %0d want 0", d_cnt[1]); end
    if (d_spc[1] !== 1'b0) begin n_fail++; $display("FAIL flush_run_pc: got %b want 0", d_spc[1]); end
  endtask

  task automatic test_freeze();
    do_reset();
    load_instr(16'h7777);
    hz_b = 1'b1;
    tick();
    hz_b = 1'b0; ex_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks += 2;
      if ({d_spc[1], d_bub[1]} !== 2'b10) begin n_fail++; $display("FAIL freeze_ctl%0d: got %b want 10", k, {d_spc[1], d_bub[1]}); end
      if (d_cnt[1] !== 4'd2) begin n_fail++; $display("FAIL freeze_cnt%0d: got %0d want 2", k, d_cnt[1]); end
      tick();
    end
    ex_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks += 2;
      if (d_cnt[1] !== 4'(2 - k)) begin n_fail++; $display("FAIL thaw_cnt%0d: got %0d want %0d", k, d_cnt[1], 2 - k); end
      if (d_bub[1] !== 1'b1) begin n_fail++; $display("FAIL thaw_bub%0d: got %b want 1", k, d_bub[1]); end
      tick();
    end
    #1;
    n_checks += 2;
    if ({d_spc[1], d_bub[1], d_cnt[1]} !== 6'b00_0000) begin n_fail++; $display("FAIL thaw_done: got %b/%b/%0d want 0/0/0", d_spc[1], d_bub[1], d_cnt[1]); end
    if (d_instr[1] !== 16'h7777) begin n_fail++; $display("FAIL thaw_hold: got %h want 7777", d_instr[1]); end
  endtask

  // Hazard held high on LOAD_LAT=2: every RUN cycle re-detects, so three back-to-back stalls.
  task automatic test_back_to_back();
    do_reset();
    load_instr(16'h0E01);
    hz_a = 1'b1; fetch_instr = 16'h0E02;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks += 3;
      if (d_bub[2] !== 1'b1) begin n_fail++; $display("FAIL b2b_bub%0d: got %b want 1", k, d_bub[2]); end
      if (d_cnt[2] !== 4'(k % 2)) begin n_fail++; $display("FAIL b2b_cnt%0d: got %0d want %0d", k, d_cnt[2], k % 2); end
      if (d_instr[2] !== 16'h0E01) begin n_fail++; $display("FAIL b2b_hold%0d: got %h want 0e01", k, d_instr[2]); end
      tick();
    end
    hz_a = 1'b0; #1;
    n_checks++;
    if (d_bub[2] !== 1'b0) begin n_fail++; $display("FAIL b2b_release: got %b want 0", d_bub[2]); end
    tick(); #1;
    n_checks++;
    if (d_instr[2] !== 16'h0E02) begin n_fail++; $display("FAIL b2b_reload: got %h want 0e02", d_instr[2]); end
`ifdef STALL_STATS_EN
    n_checks++;
    if (d_total[2] !== 16'd6) begin n_fail++; $display("FAIL stats_total: got %0d want 6", d_total[2]); end
    flush = 1'b1;
    tick(); flush = 1'b0; #1;
    n_checks++;
    if (d_total[2] !== 16'd6) begin n_fail++; $display("FAIL stats_flush: got %0d want 6", d_total[2]); end
`endif
  endtask

  task automatic test_random();
    logic [1:0] e;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      ex_ready    = ($urandom_range(0, 4) != 0);
      hz_a        = ($urandom_range(0, 2) == 0);
      hz_b        = ($urandom_range(0, 2) == 0);
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_instr = 16'($urandom);
      #1;
      for (int i = 0; i < 3; i++) begin
        n_checks += 3;
        if (d_instr[i] !== m_instr[i]) begin n_fail++; $display("FAIL rnd_instr[%0d] c%0d: got %h want %h", i, c, d_instr[i], m_instr[i]); end
        if (d_valid[i] !== m_valid[i]) begin n_fail++; $display("FAIL rnd_valid[%0d] c%0d: got %b want %b", i, c, d_valid[i], m_valid[i]); end
        if (d_cnt[i] !== 4'(m_left[i])) begin n_fail++; $display("FAIL rnd_cnt[%0d] c%0d: got %0d want %0d", i, c, d_cnt[i], m_left[i]); end
`ifdef STALL_STATS_EN
        n_checks++;
        if (d_total[i] !== 16'(m_total[i])) begin n_fail++; $display("FAIL rnd_total[%0d] c%0d: got %0d want %0d", i, c, d_total[i], m_total[i]); end
`endif
        if (rst_n) begin
          e = exp_ctl(i);
          n_checks++;
          if ({d_spc[i], d_bub[i]} !== e) begin n_fail++; $display("FAIL rnd_ctl[%0d] c%0d: got %b want %b", i, c, {d_spc[i], d_bub[i]}, e); end
        end
      end
      tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_lat1();
    test_lat3();
    test_flush_in_stall();
    test_freeze();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
